// File: rtl/nios_ram_pl.sv
// nios_ram_pl -- pipelined Avalon-MM on-chip RAM slave for the Nios data master.
//
// A single-port word-addressed RAM with per-byte write enables. Its read latency
// can be set to 1 or 2 cycles. An optional sequencer zero-fills the whole array
// after every reset.
//
// Ports
//   clk            in   rising-edge clock for all logic
//   reset          in   synchronous, active-high reset
//   reset_req      in   pending-reset request; stalls new accepts
//   chipselect     in   slave select
//   read           in   read request
//   write          in   write request (wins over read when both are set)
//   address        in   word address, ADDR_WIDTH bits
//   byteenable     in   per-byte write enable, DATA_WIDTH/8 bits
//   writedata      in   write data
//   readdata       out  read data, meaningful only while readdatavalid=1
//   readdatavalid  out  one-cycle pulse per accepted read
//   waitrequest    out  1 = request not accepted this cycle
//   clear_busy     out  zero-fill in progress
//
// Bus handshake: a request is accepted on a rising edge where chipselect=1 and
// waitrequest=0. waitrequest depends only on reset, the fill state and
// reset_req. It never depends on read or write, so a master may hold a request
// until it is accepted. Every accepted read returns exactly one readdatavalid
// pulse, READ_LATENCY cycles after its accept cycle. An accepted write produces
// no response.
module nios_ram_pl #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 12,
    parameter int    READ_LATENCY   = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = "nios_RAM.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reset_req,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic [DATA_WIDTH-1:0]     writedata,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      clear_busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    // Elaboration-time guards on the parameter set.
    if ((DATA_WIDTH % 8) != 0) begin : g_chk_width
        $error("nios_ram_pl: DATA_WIDTH must be a multiple of 8");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_chk_latency
        $error("nios_ram_pl: READ_LATENCY must be 1 or 2");
    end
    // Without the zero-fill, the only power-up contents are the image named by
    // INIT_FILE. The device memory-initialisation flow attaches that image.
    if (!CLEAR_ON_RESET && (INIT_FILE == "")) begin : g_chk_init
        $error("nios_ram_pl: CLEAR_ON_RESET=0 needs an INIT_FILE");
    end

    // While reset is high the block is in its RESET condition, and the outputs
    // are forced to their reset values directly from the reset input. The state
    // register is preloaded with the post-reset state. This lets the first
    // cycle after reset already be a clear write (or an open bus).
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    // One extra MSB: it is set by the increment past the last word and marks
    // completion, so the counter never wraps to 0 while still filling.
    logic [ADDR_WIDTH:0]      clr_addr_q, clr_addr_d;
    logic [READ_LATENCY-1:0]  vld_q, vld_d;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [DATA_WIDTH-1:0]    rd_q;

    logic                     mem_we;
    logic [BE_WIDTH-1:0]      mem_be;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     wr_acc;
    logic                     rd_acc;

    assign waitrequest = reset | (state_q != ST_RUN) | reset_req;
    assign wr_acc      = chipselect & write & ~waitrequest;
    // A simultaneous read+write is a write only.
    assign rd_acc      = chipselect & read & ~write & ~waitrequest;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = address;
        mem_wdata  = writedata;
        case (state_q)
            ST_CLEAR: begin
                mem_we     = ~reset;
                mem_be     = '1;
                mem_addr   = clr_addr_q[ADDR_WIDTH-1:0];
                mem_wdata  = '0;
                clr_addr_d = clr_addr_q + (ADDR_WIDTH+1)'(1);
                if (clr_addr_d[ADDR_WIDTH]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = wr_acc;
                mem_be = byteenable;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // The accept flag enters at bit 0 and leaves as readdatavalid at the top bit.
        vld_d = (vld_q << 1) | READ_LATENCY'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            vld_q      <= vld_d;
        end
    end

    // Storage array: no reset. Only the zero-fill changes it outside bus writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Synchronous array output, loaded on the accept edge. A write accepted on a
    // later edge cannot change data that has already been captured.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            rd_q <= mem[address];
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign readdata = reset ? '0 : rd_q;
    end else begin : g_lat2
        // Second stage. It updates only when data moves through, so readdata
        // holds its last value between pulses.
        logic [DATA_WIDTH-1:0] out_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                out_q <= '0;
            end else if (vld_q[0]) begin
                out_q <= rd_q;
            end
        end
        assign readdata = reset ? '0 : out_q;
    end

    assign readdatavalid = ~reset & vld_q[READ_LATENCY-1];
    assign clear_busy    = reset ? CLEAR_ON_RESET : (state_q == ST_CLEAR);

endmodule

// File: tb/tb_nios_ram_pl.sv
// Directed testbench for nios_ram_pl.
// u0: ADDR_WIDTH=4, READ_LATENCY=2, CLEAR_ON_RESET=1.
// u1: ADDR_WIDTH=4, READ_LATENCY=1, CLEAR_ON_RESET=0.
// Inputs change at the falling edge. Outputs are sampled at the falling edge
// (or #1 after it) before new inputs are driven. In these comments, "cycle c"
// is the period that contains the falling edge where loop index c is sampled.
module tb_nios_ram_pl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = DW / 8;

    logic          clk;
    logic          reset;

    logic          rq0, cs0, rd0, wr0;
    logic [AW-1:0] addr0;
    logic [BW-1:0] be0;
    logic [DW-1:0] wd0, rdata0;
    logic          rdv0, wait0, busy0;

    logic          rq1, cs1, rd1, wr1;
    logic [AW-1:0] addr1;
    logic [BW-1:0] be1;
    logic [DW-1:0] wd1, rdata1;
    logic          rdv1, wait1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];

    nios_ram_pl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) u0 (
        .clk(clk), .reset(reset), .reset_req(rq0), .chipselect(cs0), .read(rd0),
        .write(wr0), .address(addr0), .byteenable(be0), .writedata(wd0),
        .readdata(rdata0), .readdatavalid(rdv0), .waitrequest(wait0), .clear_busy(busy0)
    );

    nios_ram_pl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
    ) u1 (
        .clk(clk), .reset(reset), .reset_req(rq1), .chipselect(cs1), .read(rd1),
        .write(wr1), .address(addr1), .byteenable(be1), .writedata(wd1),
        .readdata(rdata1), .readdatavalid(rdv1), .waitrequest(wait1), .clear_busy(busy1)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    // Driver tasks.
    task automatic idle0();
        cs0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; be0 = '0; wd0 = '0;
    endtask

    task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        cs0 = 1'b1; wr0 = 1'b1; rd0 = 1'b0; addr0 = a; wd0 = d; be0 = be;
        @(negedge clk);
        idle0();
    endtask

    // Issues one read. Returns the data and the number of cycles from the
    // issue cycle to the cycle where readdatavalid is seen (bounded to 8).
    task automatic read0(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        cs0 = 1'b1; rd0 = 1'b1; wr0 = 1'b0; addr0 = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) idle0();
        end while (!rdv0 && lat < 8);
        d = rdata0;
    endtask

    // Counts clear_busy cycles from the current sample point (bounded).
    task automatic count_clear(output int cnt, output logic wr_low);
        cnt = 0;
        wr_low = 1'b0;
        while (busy0 && cnt < 100) begin
            cnt++;
            if (!wait0) wr_low = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rq0 = 1'b0; addr0 = '0; idle0();
        rq1 = 1'b0; cs1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; be1 = '0; wd1 = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (rdata0 !== '0) begin n_fail++; $display("FAIL reset_readdata0: got %h want 0", rdata0); end
        n_checks++; if (rdv0 !== 1'b0) begin n_fail++; $display("FAIL reset_rdv0: got %b want 0", rdv0); end
        n_checks++; if (wait0 !== 1'b1) begin n_fail++; $display("FAIL reset_wait0: got %b want 1", wait0); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL reset_busy0: got %b want 1", busy0); end
        n_checks++; if (rdata1 !== '0) begin n_fail++; $display("FAIL reset_readdata1: got %h want 0", rdata1); end
        n_checks++; if (wait1 !== 1'b1) begin n_fail++; $display("FAIL reset_wait1: got %b want 1", wait1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    endtask

    task automatic test_clear();
        int   cnt;
        logic wr_low;
        reset = 1'b0;
        #1;
        n_checks++; if (wait1 !== 1'b0) begin n_fail++; $display("FAIL norclear_wait_falls: got %b want 0", wait1); end
        count_clear(cnt, wr_low);
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL clear_cycles: got %0d want 16", cnt); end
        n_checks++; if (wr_low !== 1'b0) begin n_fail++; $display("FAIL clear_wait_high: got low=%b want 0", wr_low); end
        n_checks++; if (wait0 !== 1'b0) begin n_fail++; $display("FAIL clear_wait_falls: got %b want 0", wait0); end
        // Back-to-back readback of the whole array through the scoreboard.
        for (int c = 0; c < 20; c++) begin
            if (rdv0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL clear_read_extra: got pulse data %h want none", rdata0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (rdata0 !== e) begin n_fail++; $display("FAIL clear_read: got %h want %h", rdata0, e); end
                end
            end
            if (c < 16) begin
                cs0 = 1'b1; rd0 = 1'b1; addr0 = AW'(c);
                exp_q.push_back('0);
            end else begin
                idle0();
            end
            @(negedge clk);
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clear_read_missing: got %0d outstanding want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_byteenable();
        logic [DW-1:0] d;
        int            lat;
        write0(4'd3, 32'hAABBCCDD, 4'b1111);
        write0(4'd3, 32'h11223344, 4'b0101);
        read0(4'd3, d, lat);
        n_checks++; if (d !== 32'hAA22CC44) begin n_fail++; $display("FAIL byteenable: got %h want aa22cc44", d); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL read_latency2: got %0d want 2", lat); end
        write0(4'd3, 32'hFFFFFFFF, 4'b0000);
        read0(4'd3, d, lat);
        n_checks++; if (d !== 32'hAA22CC44) begin n_fail++; $display("FAIL be_zero_noop: got %h want aa22cc44", d); end
    endtask

    task automatic test_read_write_same_cycle();
        logic [DW-1:0] d;
        int            lat;
        int            pulses;
        cs0 = 1'b1; rd0 = 1'b1; wr0 = 1'b1; addr0 = 4'd9; wd0 = 32'h00001234; be0 = 4'b1111;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) idle0();
            if (rdv0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rw_no_pulse: got %0d pulses want 0", pulses); end
        read0(4'd9, d, lat);
        n_checks++; if (d !== 32'h00001234) begin n_fail++; $display("FAIL rw_is_write: got %h want 00001234", d); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        write0(4'd1, 32'h1, 4'b1111);
        write0(4'd2, 32'h2, 4'b1111);
        write0(4'd3, 32'h3, 4'b1111);
        for (int c = 0; c < 8; c++) begin
            exp_v = (c >= 2 && c <= 4);
            n_checks++; if (rdv0 !== exp_v) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, rdv0, exp_v); end
            if (exp_v) begin
                n_checks++; if (rdata0 !== 32'(c - 1)) begin n_fail++; $display("FAIL b2b_data c=%0d: got %h want %h", c, rdata0, 32'(c - 1)); end
            end
            if (c < 3) begin
                cs0 = 1'b1; rd0 = 1'b1; addr0 = AW'(c + 1);
            end else begin
                idle0();
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ordering();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        write0(4'd5, 32'h55, 4'b1111);
        for (int c = 0; c < 6; c++) begin
            exp_v = (c == 2 || c == 4);
            exp_d = (c == 2) ? 32'h55 : 32'h99;
            n_checks++; if (rdv0 !== exp_v) begin n_fail++; $display("FAIL order_valid c=%0d: got %b want %b", c, rdv0, exp_v); end
            if (exp_v) begin
                n_checks++; if (rdata0 !== exp_d) begin n_fail++; $display("FAIL order_data c=%0d: got %h want %h", c, rdata0, exp_d); end
            end
            idle0();
            if (c == 0 || c == 2) begin
                cs0 = 1'b1; rd0 = 1'b1; addr0 = 4'd5;
            end else if (c == 1) begin
                cs0 = 1'b1; wr0 = 1'b1; addr0 = 4'd5; wd0 = 32'h99; be0 = 4'b1111;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_req();
        logic exp_v;
        logic exp_w;
        write0(4'd7, 32'h77, 4'b1111);
        for (int c = 0; c < 8; c++) begin
            exp_v = (c == 2);
            n_checks++; if (rdv0 !== exp_v) begin n_fail++; $display("FAIL rreq_valid c=%0d: got %b want %b", c, rdv0, exp_v); end
            if (exp_v) begin
                n_checks++; if (rdata0 !== 32'h77) begin n_fail++; $display("FAIL rreq_data: got %h want 00000077", rdata0); end
            end
            if (c <= 3) begin
                cs0 = 1'b1; rd0 = 1'b1; addr0 = 4'd7;
                rq0 = (c >= 1);
            end else begin
                idle0();
                rq0 = 1'b0;
            end
            #1;
            exp_w = (c >= 1 && c <= 3);
            n_checks++; if (wait0 !== exp_w) begin n_fail++; $display("FAIL rreq_wait c=%0d: got %b want %b", c, wait0, exp_w); end
            @(negedge clk);
        end
    endtask

    task automatic test_rl1();
        logic exp_v;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rl1_busy: got %b want 0", busy1); end
        for (int c = 0; c < 5; c++) begin
            exp_v = (c == 2);
            n_checks++; if (rdv1 !== exp_v) begin n_fail++; $display("FAIL rl1_valid c=%0d: got %b want %b", c, rdv1, exp_v); end
            if (exp_v) begin
                n_checks++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rl1_data: got %h want deadbeef", rdata1); end
            end
            cs1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; be1 = '0;
            if (c == 0) begin
                cs1 = 1'b1; wr1 = 1'b1; addr1 = 4'd2; wd1 = 32'hDEADBEEF; be1 = 4'b1111;
            end else if (c == 1) begin
                cs1 = 1'b1; rd1 = 1'b1; addr1 = 4'd2;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int            cnt;
        logic          wr_low;
        logic [DW-1:0] d;
        int            lat;
        // Reset one cycle after a read accept: the pending pulse must be dropped.
        cs0 = 1'b1; rd0 = 1'b1; addr0 = 4'd7;
        @(negedge clk);
        idle0();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (rdv0 !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", rdv0); end
        // The clear runs with counter 0 in this cycle. Move on to the cycle
        // where the counter is 7, then reset there.
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL midclr_busy: got %b want 1", busy0); end
        n_checks++; if (wait0 !== 1'b1) begin n_fail++; $display("FAIL midclr_wait: got %b want 1", wait0); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        count_clear(cnt, wr_low);
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL midclr_restart: got %0d cycles want 16", cnt); end
        n_checks++; if (wr_low !== 1'b0) begin n_fail++; $display("FAIL midclr_wait_high: got low=%b want 0", wr_low); end
        read0(4'd7, d, lat);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL midclr_addr7: got %h want 0", d); end
        read0(4'd3, d, lat);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL midclr_addr3: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_rl1();
        test_byteenable();
        test_read_write_same_cycle();
        test_back_to_back();
        test_ordering();
        test_reset_req();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_ram_pl.md
# nios_ram_pl

Parametrised, pipelined Avalon-MM on-chip RAM slave for the Nios system. It replaces the fixed 4096×32 single-port RAM with configurable width, depth and read latency, and adds explicit `read`, `readdatavalid` and `waitrequest` signalling. It also provides an optional hardware zero-fill sequencer that clears the whole array after every reset. It sits on the Nios data master interconnect as a memory-mapped slave.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.
- `ADDR_WIDTH`, default 12: word address width; depth is `2**ADDR_WIDTH`.
- `READ_LATENCY`, default 1: cycles from read accept to `readdatavalid`; legal values are 1 and 2.
- `CLEAR_ON_RESET`, default 1: when 1, zero-fill the array after reset; when 0, the array is initialised only from `INIT_FILE` at configuration.
- `INIT_FILE`, default "nios_RAM.hex": initial array contents.

**Ports**
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `reset_req`, in, 1: pending-reset request; blocks acceptance of new transfers.
- `chipselect`, in, 1: slave select.
- `read`, in, 1: read request.
- `write`, in, 1: write request.
- `address`, in, ADDR_WIDTH: word address.
- `byteenable`, in, DATA_WIDTH/8: per-byte write enable.
- `writedata`, in, DATA_WIDTH: write data.
- `readdata`, out, DATA_WIDTH: read data; valid only when `readdatavalid`=1.
- `readdatavalid`, out, 1: one-cycle pulse per accepted read.
- `waitrequest`, out, 1: 1 means the request is not accepted this cycle.
- `clear_busy`, out, 1: zero-fill in progress.

## Operation

**States**
- RESET: entered while `reset`=1.
- On the first cycle with `reset`=0:
  - CLEAR when `CLEAR_ON_RESET`=1.
  - RUN otherwise.

**CLEAR**
- Internal counter `clr_addr` starts at 0.
- Each cycle writes all-zero data to `clr_addr` with all bytes enabled, then increments.
- After writing address `2**ADDR_WIDTH-1`, the block moves to RUN on the next cycle.
- Bus requests are ignored and `waitrequest`=1 throughout.

**RUN**
- `waitrequest` = `reset_req`.
- Write accept: `chipselect & write & ~waitrequest`.
  - Only bytes with `byteenable[i]`=1 are updated.
  - `byteenable`=0 is a legal no-op write.
- Read accept: `chipselect & read & ~write & ~waitrequest`.
- `read` and `write` together: treated as a write only; no `readdatavalid` is produced.
- Valid pipeline:
  - A shift register of depth `READ_LATENCY` carries the accept flag.
  - A read accepted at cycle t produces exactly one `readdatavalid` pulse at t+`READ_LATENCY`.
- Back-to-back reads are accepted every cycle, giving full throughput.

**Ordering**
- Data returned is the array contents as of the accept edge.
- A write accepted after a read (including at t+1 with `READ_LATENCY`=2) does not affect that read's data.

**`reset_req`**
- Stalls new accepts.
- In-flight reads still complete and pulse `readdatavalid`.

**Reset**
- Reset asserted mid-operation flushes the valid pipeline: pending pulses are dropped.
- Reset mid-CLEAR restarts the fill from address 0.
- Array contents are not reset except by CLEAR.

**Address wrap:** `clr_addr` is ADDR_WIDTH+1 bits wide; its MSB marks completion, so there is no wrap to 0 before the state exits.

## Timing

**Output values during reset**
- `readdata` = 0
- `readdatavalid` = 0
- `waitrequest` = 1
- `clear_busy` = 1 if `CLEAR_ON_RESET`, else 0

**CLEAR duration**
- Exactly `2**ADDR_WIDTH` cycles, with `clear_busy`=1 for all of them.
- `waitrequest` falls on the cycle after the last clear write.
- With `CLEAR_ON_RESET`=0, `waitrequest` falls on the first cycle after reset deasserts.

**Latencies**
- Write: committed at accept edge t; a read accepted at t+1 returns the new data.
- Read latency 1: data is taken from the synchronous array output.
- Read latency 2: adds one output register, and `readdata` holds its last value between pulses.
- Both variants stall nothing; `waitrequest` never depends on `read` or `write`.

**Throughput:** one transfer per cycle.

## Test plan

- **Clear:** `ADDR_WIDTH`=4, `CLEAR_ON_RESET`=1; release reset.
  - Required: `clear_busy` high for 16 cycles, then `waitrequest` falls.
  - Then reading addresses 0–15 returns 0x00000000 each.
- **Byte-enable write:**
  - Write 0xAABBCCDD to addr 3 with be=4'b1111.
  - Then write 0x11223344 to addr 3 with be=4'b0101.
  - Then read addr 3. Required: 0xAA22CC44.
- **Latency:** `READ_LATENCY`=2; issue reads of addr 1, 2, 3 on consecutive cycles holding 0x1, 0x2, 0x3.
  - Required: `readdatavalid` high at t+2, t+3, t+4 with data 0x1, 0x2, 0x3.
- **Ordering:** `READ_LATENCY`=2; read addr 5 (holding 0x55) at t, write 0x99 to addr 5 at t+1.
  - Required: data at t+2 is 0x55.
  - A read at t+2 returns 0x99.
- **`reset_req` stall:** read accepted at t; `reset_req`=1 from t+1 to t+3 while `chipselect` and `read` are held.
  - Required: the pulse for t still arrives.
  - `waitrequest`=1 for 3 cycles, with no accepts or extra pulses in that window.
- **Reset mid-activity:**
  - Assert `reset` one cycle after a read accept. Required: no `readdatavalid`.
  - Assert `reset` at `clr_addr`=7 during CLEAR. Required: a full 16-cycle clear restarts.
